// File: rtl/cache_wrr_arb_pkg.sv
// Shared types and helpers for the cache request-fabric weighted round-robin arbiter.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
//
// Contents: arb_state_e FSM encoding, circular rotate helpers and a one-hot to index
// encoder. The helpers work on a MAX_N-bit carrier so they can serve any requester
// count up to MAX_N; callers widen with a cast and truncate the result back to N bits.
// Optional feature macro used by this block: CACHE_ARB_TIMEOUT_EN.
package cache_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  localparam int MAX_N  = 64;
  localparam int MAX_IW = 6;

  typedef logic [MAX_N-1:0] vec_t;

  // Rotate the low n bits of v right by sh: result bit i = v[(i + sh) mod n].
  function automatic vec_t rotr(input vec_t v, input int sh, input int n);
    vec_t r;
    r = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < n) r[i] = v[MAX_IW'((i + sh) % n)];
    end
    return r;
  endfunction

  // Rotate the low n bits of v left by sh: result bit i = v[(i - sh) mod n].
  function automatic vec_t rotl(input vec_t v, input int sh, input int n);
    vec_t r;
    r = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < n) r[i] = v[MAX_IW'((i - sh + n) % n)];
    end
    return r;
  endfunction

  // Index of the set bit of a one-hot vector; 0 for an all-zero vector.
  function automatic logic [MAX_IW-1:0] onehot2idx(input vec_t v);
    logic [MAX_IW-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (v[i]) idx = idx | MAX_IW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/cache_wrr_arb_if.sv
// Request/grant bundle between the cache requesters and the arbiter.
// Latency: n/a (wiring only).
// Backpressure: none; req is a level held by the requester until it is granted.
//
// Signals: req[N], req_end[N], weight[N*WEIGHT_W] (requester side);
//          gnt[N], gnt_vld, gnt_id[$clog2(N)], timeout (arbiter side).
// timeout exists only when CACHE_ARB_TIMEOUT_EN is defined.
interface cache_wrr_arb_if #(
  parameter int N        = 8,
  parameter int WEIGHT_W = 4
);

  logic [N-1:0]          req;
  logic [N-1:0]          req_end;
  logic [N*WEIGHT_W-1:0] weight;
  logic [N-1:0]          gnt;
  logic                  gnt_vld;
  logic [$clog2(N)-1:0]  gnt_id;
`ifdef CACHE_ARB_TIMEOUT_EN
  logic                  timeout;

  modport master (output req, req_end, weight, input gnt, gnt_vld, gnt_id, timeout);
  modport slave  (input req, req_end, weight, output gnt, gnt_vld, gnt_id, timeout);
`else
  modport master (output req, req_end, weight, input gnt, gnt_vld, gnt_id);
  modport slave  (input req, req_end, weight, output gnt, gnt_vld, gnt_id);
`endif

endinterface

// File: rtl/cache_wrr_arb_ffs.sv
// Circular find-first-set starting at a pointer, upward or downward (REFLECTION).
// Latency: purely combinational.
// Backpressure: n/a.
//
// Ports: i_req[N] candidates, i_ptr search start; o_win one-hot winner,
//        o_win_idx winner index, o_any = |i_req.
// Downward search is done by bit-reversing the request vector so the same
// rotate / isolate-lowest-bit / rotate-back path serves both directions.
module cache_arb_ffs
  import cache_arb_pkg::*;
#(
  parameter int N          = 8,
  parameter int REFLECTION = 1
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [N-1:0]         o_win,
  output logic [$clog2(N)-1:0] o_win_idx,
  output logic                 o_any
);

  localparam int IW = $clog2(N);

  logic [N-1:0] w_srch;
  logic [N-1:0] w_rot;
  logic [N-1:0] w_iso;
  logic [N-1:0] w_found;
  logic [N-1:0] w_win;
  int           w_sh;

  always_comb begin
    w_srch = '0;
    w_win  = '0;
    for (int i = 0; i < N; i++) begin
      w_srch[i] = (REFLECTION != 0) ? i_req[N-1-i] : i_req[i];
    end
    // In reversed space, position ptr maps to N-1-ptr.
    w_sh    = (REFLECTION != 0) ? (N - 1 - int'(i_ptr)) : int'(i_ptr);
    w_rot   = N'(rotr(vec_t'(w_srch), w_sh, N));
    w_iso   = w_rot & (~w_rot + N'(1));
    w_found = N'(rotl(vec_t'(w_iso), w_sh, N));
    for (int i = 0; i < N; i++) begin
      w_win[i] = (REFLECTION != 0) ? w_found[N-1-i] : w_found[i];
    end
  end

  assign o_win     = w_win;
  assign o_win_idx = IW'(onehot2idx(vec_t'(w_win)));
  assign o_any     = |i_req;

endmodule

// File: rtl/cache_wrr_arb.sv
// Weighted round-robin arbiter with grant lock for the rw_cache request fabric.
// Latency: req in IDLE -> gnt after 1 cycle; handover on release with 0 idle cycles.
// Backpressure: a grant is held until the owner pulses req_end (or the watchdog fires).
//
// Ports: clk, rst_n (async active-low); bus (cache_wrr_arb_if.slave):
//        req/req_end/weight in, gnt/gnt_vld/gnt_id out, timeout out (macro only).
// Optional feature: CACHE_ARB_TIMEOUT_EN adds the MAX_HOLD parameter, a hold
// counter and the timeout pulse; without it a grant is held indefinitely.
module cache_wrr_arb #(
  parameter int N          = 8,
  parameter int WEIGHT_W   = 4,
  parameter int REFLECTION = 1
`ifdef CACHE_ARB_TIMEOUT_EN
  , parameter int MAX_HOLD = 256
`endif
) (
  input  logic           clk,
  input  logic           rst_n,
  cache_wrr_arb_if.slave bus
);

  import cache_arb_pkg::*;

  localparam int IW = $clog2(N);

  arb_state_e          r_state, w_state_nxt;
  logic [N-1:0]        r_gnt, w_gnt_nxt;
  logic [IW-1:0]       r_gid, w_gid_nxt;
  logic [IW-1:0]       r_ptr, w_ptr_nxt;
  logic [WEIGHT_W-1:0] r_credit     [N];
  logic [WEIGHT_W-1:0] w_credit_nxt [N];
  logic [WEIGHT_W-1:0] w_wt         [N];
  logic [WEIGHT_W-1:0] w_win_credit;
  logic [IW-1:0]       w_arb_ptr;
  logic [N-1:0]        w_win;
  logic [IW-1:0]       w_win_idx;
  logic                w_any;
  logic                w_end_hit;
  logic                w_force;
  logic                w_release;
  logic                w_arb;
  logic                w_pass;
  int                  w_idx;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
    if (REFLECTION != 0) return (idx == '0) ? IW'(N - 1) : idx - IW'(1);
    else                 return (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
  endfunction

  always_comb begin
    for (int i = 0; i < N; i++) w_wt[i] = bus.weight[i*WEIGHT_W +: WEIGHT_W];
  end

  // req_end only counts on the bit that actually owns the grant.
  assign w_end_hit = (r_state == LOCK) && ((bus.req_end & r_gnt) != '0);

`ifdef CACHE_ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0] r_hold;

  // r_hold counts completed hold cycles, so the MAX_HOLD-th cycle sees MAX_HOLD-1.
  assign w_force     = (r_state == LOCK) && !w_end_hit && (r_hold == HOLD_W'(MAX_HOLD - 1));
  assign bus.timeout = w_force;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            r_hold <= '0;
    else if (r_state == LOCK && !w_release) r_hold <= r_hold + HOLD_W'(1);
    else                                   r_hold <= '0;
  end
`else
  assign w_force = 1'b0;
`endif

  assign w_release = w_end_hit | w_force;
  assign w_arb     = (r_state == IDLE) | w_release;
  // A forced release skips the owner so it cannot immediately win again.
  assign w_arb_ptr = w_force ? next_idx(r_gid) : r_ptr;

  cache_arb_ffs #(
    .N          (N),
    .REFLECTION (REFLECTION)
  ) u_ffs (
    .i_req     (bus.req),
    .i_ptr     (w_arb_ptr),
    .o_win     (w_win),
    .o_win_idx (w_win_idx),
    .o_any     (w_any)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_gnt_nxt    = r_gnt;
    w_gid_nxt    = r_gid;
    w_ptr_nxt    = r_ptr;
    w_credit_nxt = r_credit;
    w_win_credit = '0;
    w_pass       = 1'b1;
    w_idx        = 0;
    if (w_force) w_credit_nxt[r_gid] = '0;
    if (w_arb) begin
      w_ptr_nxt = w_arb_ptr;
      if (w_any) begin
        // Everyone between the search start and the winner was passed over.
        for (int k = 0; k < N; k++) begin
          w_idx = (REFLECTION != 0) ? ((int'(w_arb_ptr) + N - k) % N)
                                    : ((int'(w_arb_ptr) + k) % N);
          if (IW'(w_idx) == w_win_idx) w_pass = 1'b0;
          if (w_pass) w_credit_nxt[IW'(w_idx)] = '0;
        end
        // Fresh burst reloads max(weight,1)-1; an ongoing burst counts down.
        if (w_credit_nxt[w_win_idx] == '0)
          w_win_credit = (w_wt[w_win_idx] == '0) ? '0 : w_wt[w_win_idx] - WEIGHT_W'(1);
        else
          w_win_credit = w_credit_nxt[w_win_idx] - WEIGHT_W'(1);
        w_credit_nxt[w_win_idx] = w_win_credit;
        w_ptr_nxt   = (w_win_credit != '0) ? w_win_idx : next_idx(w_win_idx);
        w_gnt_nxt   = w_win;
        w_gid_nxt   = w_win_idx;
        w_state_nxt = LOCK;
      end else begin
        w_gnt_nxt   = '0;
        w_gid_nxt   = '0;
        w_state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_gid   <= '0;
      r_ptr   <= '0;
      for (int i = 0; i < N; i++) r_credit[i] <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_gnt    <= w_gnt_nxt;
      r_gid    <= w_gid_nxt;
      r_ptr    <= w_ptr_nxt;
      r_credit <= w_credit_nxt;
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.gnt_vld = |r_gnt;
  assign bus.gnt_id  = r_gid;

endmodule

// File: tb/tb_cache_wrr_arb.sv
// Directed bench for cache_wrr_arb: two N=4 instances (REFLECTION 0 and 1) share
// req/weight; each can auto-release by echoing its own gnt onto req_end.
module tb_cache_wrr_arb;

  logic        clk;
  logic        rst_n;
  logic [3:0]  tb_req;
  logic [3:0]  tb_end;
  logic [15:0] tb_wt;
  logic        auto_rel;
  int          n_vec;
  int          n_bad;

`ifdef CACHE_ARB_TIMEOUT_EN
  localparam int LOCK_CYC = 4;
`else
  localparam int LOCK_CYC = 20;
`endif

  cache_wrr_arb_if #(.N(4), .WEIGHT_W(4)) if0 ();
  cache_wrr_arb_if #(.N(4), .WEIGHT_W(4)) if1 ();

  assign if0.req     = tb_req;
  assign if1.req     = tb_req;
  assign if0.weight  = tb_wt;
  assign if1.weight  = tb_wt;
  assign if0.req_end = auto_rel ? if0.gnt : tb_end;
  assign if1.req_end = auto_rel ? if1.gnt : tb_end;

  cache_wrr_arb #(
    .N(4), .WEIGHT_W(4), .REFLECTION(0)
`ifdef CACHE_ARB_TIMEOUT_EN
    , .MAX_HOLD(8)
`endif
  ) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
  );

  cache_wrr_arb #(
    .N(4), .WEIGHT_W(4), .REFLECTION(1)
`ifdef CACHE_ARB_TIMEOUT_EN
    , .MAX_HOLD(8)
`endif
  ) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  rend;
    logic        autor;
    logic [15:0] wt;
    logic [3:0]  exp0;
    logic        chk1;
    logic [3:0]  exp1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic [3:0] req, input logic [3:0] rend,
                              input logic autor, input logic [15:0] wt, input logic [3:0] exp0,
                              input logic chk1, input logic [3:0] exp1);
    vec_t v;
    v.rst = rst; v.req = req; v.rend = rend; v.autor = autor; v.wt = wt;
    v.exp0 = exp0; v.chk1 = chk1; v.exp1 = exp1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [3:0] ag, input logic av,
                     input logic [1:0] ai, input logic [3:0] eg);
    logic [1:0] ei;
    logic       ev;
    ev = |eg;
    ei = '0;
    for (int i = 0; i < 4; i++) if (eg[i]) ei = 2'(i);
    n_vec++;
    if (ag !== eg || av !== ev || ai !== ei) begin
      n_bad++;
      $display("FAIL %s: got gnt=%b vld=%b id=%0d, expected gnt=%b vld=%b id=%0d",
               nm, ag, av, ai, eg, ev, ei);
    end
  endtask

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0; n_bad = 0;
    rst_n = 1'b0; tb_req = '0; tb_end = '0; tb_wt = 16'h1111; auto_rel = 1'b0;

    // Rotation, weights 1: REFLECTION=0 -> 0,1,2,3,0 ; REFLECTION=1 -> 0,3,2,1,0
    tbl.push_back(mk(1, 4'b1111, 4'b0000, 1, 16'h1111, 4'b0001, 1, 4'b0001));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 1, 16'h1111, 4'b0010, 1, 4'b1000));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 1, 16'h1111, 4'b0100, 1, 4'b0100));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 1, 16'h1111, 4'b1000, 1, 4'b0010));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 1, 16'h1111, 4'b0001, 1, 4'b0001));
    // Weights {3,1,1,1}, REFLECTION=0 -> 0,0,0,1,2,3,0,0,0 back to back
    tbl.push_back(mk(1, 4'b1111, 4'b0000, 1, 16'h1113, 4'b0001, 0, 4'b0000));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 1, 16'h1113, 4'b0001, 0, 4'b0000));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 1, 16'h1113, 4'b0001, 0, 4'b0000));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 1, 16'h1113, 4'b0010, 0, 4'b0000));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 1, 16'h1113, 4'b0100, 0, 4'b0000));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 1, 16'h1113, 4'b1000, 0, 4'b0000));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 1, 16'h1113, 4'b0001, 0, 4'b0000));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 1, 16'h1113, 4'b0001, 0, 4'b0000));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 1, 16'h1113, 4'b0001, 0, 4'b0000));
    // Single request, release to IDLE, re-grant on same-index req+req_end, stray req_end
    tbl.push_back(mk(1, 4'b0100, 4'b0000, 0, 16'h1111, 4'b0100, 1, 4'b0100));
    tbl.push_back(mk(0, 4'b0000, 4'b0100, 0, 16'h1111, 4'b0000, 1, 4'b0000));
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 0, 16'h1111, 4'b0100, 1, 4'b0100));
    tbl.push_back(mk(0, 4'b0100, 4'b0100, 0, 16'h1111, 4'b0100, 1, 4'b0100));
    tbl.push_back(mk(0, 4'b1100, 4'b0100, 0, 16'h1111, 4'b1000, 1, 4'b1000));
    tbl.push_back(mk(0, 4'b1100, 4'b0001, 0, 16'h1111, 4'b1000, 1, 4'b1000));
    tbl.push_back(mk(0, 4'b1100, 4'b0010, 0, 16'h1111, 4'b1000, 1, 4'b1000));
    tbl.push_back(mk(0, 4'b0000, 4'b1000, 0, 16'h1111, 4'b0000, 1, 4'b0000));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_r0", if0.gnt, if0.gnt_vld, if0.gnt_id, 4'b0000);
    chk("reset_r1", if1.gnt, if1.gnt_vld, if1.gnt_id, 4'b0000);
`ifdef CACHE_ARB_TIMEOUT_EN
    chk_bit("reset_timeout", if0.timeout, 1'b0);
`endif
    rst_n = 1'b1;

    foreach (tbl[v]) begin
      tb_req = tbl[v].req; tb_end = tbl[v].rend; auto_rel = tbl[v].autor; tb_wt = tbl[v].wt;
      if (tbl[v].rst) do_reset();
      step();
      chk($sformatf("vec%0d_r0", v), if0.gnt, if0.gnt_vld, if0.gnt_id, tbl[v].exp0);
      if (tbl[v].chk1) chk($sformatf("vec%0d_r1", v), if1.gnt, if1.gnt_vld, if1.gnt_id, tbl[v].exp1);
    end

    // Lock: req[1] dropped without req_end keeps the grant; stray req_end[3] ignored
    auto_rel = 1'b0; tb_end = '0; tb_wt = 16'h1111; tb_req = 4'b0010;
    do_reset();
    step();
    chk("lock_start", if0.gnt, if0.gnt_vld, if0.gnt_id, 4'b0010);
    for (int i = 0; i < LOCK_CYC; i++) begin
      tb_req = (i < LOCK_CYC / 2) ? 4'b0000 : 4'b1101;
      step();
      chk($sformatf("lock_hold%0d", i), if0.gnt, if0.gnt_vld, if0.gnt_id, 4'b0010);
    end
    tb_end = 4'b1000;
    step();
    chk("lock_stray_end", if0.gnt, if0.gnt_vld, if0.gnt_id, 4'b0010);
    tb_req = 4'b0000; tb_end = 4'b0010;
    step();
    chk("lock_release", if0.gnt, if0.gnt_vld, if0.gnt_id, 4'b0000);
    tb_end = '0;

    // Async reset mid-LOCK with idx1 credit=2 clears grant, ptr and credits
    tb_wt = 16'h1131; tb_req = 4'b0010;
    do_reset();
    step();
    chk("rst_pre", if0.gnt, if0.gnt_vld, if0.gnt_id, 4'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", if0.gnt, if0.gnt_vld, if0.gnt_id, 4'b0000);
    #1;
    rst_n = 1'b1;
    tb_req = 4'b0011;
    step();
    chk("rst_after", if0.gnt, if0.gnt_vld, if0.gnt_id, 4'b0001);

`ifdef CACHE_ARB_TIMEOUT_EN
    // Watchdog: forced release on hold cycle 8, next requester granted after
    tb_wt = 16'h1111; tb_req = 4'b0011; tb_end = '0;
    do_reset();
    step();
    chk("to_grant", if0.gnt, if0.gnt_vld, if0.gnt_id, 4'b0001);
    chk_bit("to_cyc1", if0.timeout, 1'b0);
    for (int c = 2; c <= 8; c++) begin
      step();
      chk($sformatf("to_hold%0d", c), if0.gnt, if0.gnt_vld, if0.gnt_id, 4'b0001);
      chk_bit($sformatf("to_cyc%0d", c), if0.timeout, (c == 8));
    end
    step();
    chk("to_next", if0.gnt, if0.gnt_vld, if0.gnt_id, 4'b0010);
    chk_bit("to_after", if0.timeout, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
